time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- Front-panel controller for the time-of-day counter block.
- Sequences the set-time procedure from three pushbuttons and drives that block's cont/hora/min/sec load inputs.
- Captures the running time on entry, lets the user edit hours, then minutes, then seconds with up/down wrap, and commits the result.
- Holds the load request long enough for the counter's slow tick to sample it, and provides a blink strobe for the display of the field being edited.

Parameters:
- BLINK_HALF, 25_000_000: clock cycles per half-period of the blink strobe.
- TIMEOUT_CYC, 500_000_000: idle cycles in a SET state before an automatic commit.
- COMMIT_CYC, 100_000_000: cycles cont is held at 3'b111 in COMMIT. Must be at least one full slow-tick period of the counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn_mode  input  1  debounced level, synchronous to clock; advances the edit field.
- btn_up  input  1  debounced level; increments the selected field.
- btn_down  input  1  debounced level; decrements the selected field.
- run_hora  input  7  current hour from the counter.
- run_min  input  7  current minute from the counter.
- run_sec  input  7  current second from the counter.
- cont  output  3  load request to the counter: 000 run, 100 hora, 010 min, 001 sec, 111 commit.
- hora  output  7  edited hour, range 0..23.
- min  output  7  edited minute, range 0..59.
- sec  output  7  edited second, range 0..59.
- blink  output  1  display blank strobe for the selected field.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. reset=0 forces at once: state RUN, cont=000, hora=min=sec=0, blink=0, all counters 0, edge-detector history 0.
- Edge detection: one previous-level register per button. A press is din=1 while prev=0. State and outputs update on the clock edge that samples the press, so outputs are visible 1 cycle after the input rises. A held button yields exactly one press.
- Press priority: mode beats up/down. Up and down pressed in the same cycle means no change.
- State RUN (cont=000, blink=0):
  - mode press: capture run_hora/run_min/run_sec into hora/min/sec, go to SET_H.
  - On capture, any value above range (hora>23, min or sec>59) loads as 0.
  - up/down ignored.
- State SET_H (cont=100):
  - up: hora=23 -> 0, else +1. down: hora=0 -> 23, else -1.
  - mode: go to SET_M.
- State SET_M (cont=010): same rules on min with max 59. mode: go to SET_S.
- State SET_S (cont=001): same rules on sec with max 59. mode: go to COMMIT.
- State COMMIT (cont=111, blink=0):
  - Holds hora/min/sec stable for exactly COMMIT_CYC cycles, then goes to RUN.
  - All buttons ignored; edge history still updates, so a button held across the exit does not fire.
- Idle timeout:
  - One counter runs in SET_H, SET_M and SET_S. It clears on any press and on every state change.
  - When it reaches TIMEOUT_CYC-1 with no press, go to COMMIT with current values.
  - A press in that same cycle wins and the counter clears.
- Blink:
  - In SET states only; 0 elsewhere.
  - On entry to any SET state, blink=1 and the blink counter is 0.
  - blink toggles every BLINK_HALF cycles. A press restarts the phase with blink=1.
- Field outputs in RUN: hold the last committed values.
- Arithmetic: all field arithmetic is 7-bit. Wrap is an explicit compare, never modulo overflow.
- cont transitions occur only on state changes and are glitch-free as registered outputs.

Test Plan (BLINK_HALF=4, TIMEOUT_CYC=50, COMMIT_CYC=8):
1. Reset low mid-SET_M with min=30 -> cont=000, hora=min=sec=0, blink=0 immediately, before any clock edge. Release reset, hold all buttons 0 for 100 cycles -> state stays RUN.
2. run=23:59:58, press mode -> cont=100, hora=23, min=59, sec=58 one cycle later. Press up -> hora=0. Press down -> hora=23.
3. Press mode twice to reach SET_S with sec=58. Press up twice -> 59, then 0. Press down -> 59. mode held 20 cycles -> exactly one advance to COMMIT.
4. COMMIT entered -> cont=111 for exactly 8 cycles with values frozen. up presses during COMMIT have no effect. Then cont=000.
5. In SET_M, no press for 50 cycles -> COMMIT on cycle 50. Repeat with an up press on cycle 49 -> min+1, stays SET_M, timeout restarts.
6. In SET_H, up and down in the same cycle -> hora unchanged. mode and up together -> SET_M, hora unchanged. Blink sequence 1,1,1,1,0,0,0,0 after entry; an up press restarts it at 1.
7. run_min=75 at capture -> min=0 in SET_M.

Source files
------------

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel set-time sequencer for the time-of-day counter.
// Captures the running time, lets the user edit hours, minutes and seconds
// with up/down wrap, then holds a commit load request long enough for the
// counter's slow tick to sample it. Also drives a blink strobe for the field
// being edited.
module time_set_ctrl #(
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned COMMIT_CYC  = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [6:0] run_hora,
    input  logic [6:0] run_min,
    input  logic [6:0] run_sec,
    output logic [2:0] cont,
    output logic [6:0] hora,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       blink
);

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_SET_H  = 3'd1;
    localparam logic [2:0] ST_SET_M  = 3'd2;
    localparam logic [2:0] ST_SET_S  = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam logic [6:0]  HORA_MAX = 7'd23;
    localparam logic [6:0]  MS_MAX   = 7'd59;

    localparam logic [31:0] BLINK_LAST   = 32'(BLINK_HALF - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] COMMIT_LAST  = 32'(COMMIT_CYC - 1);

    // Wrap is an explicit compare so the 7-bit field never relies on overflow.
    function automatic logic [6:0] field_inc(input logic [6:0] v, input logic [6:0] vmax);
        return (v == vmax) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] field_dec(input logic [6:0] v, input logic [6:0] vmax);
        return (v == 7'd0) ? vmax : v - 7'd1;
    endfunction

    // Out-of-range values from the counter load as zero.
    function automatic logic [6:0] field_clamp(input logic [6:0] v, input logic [6:0] vmax);
        return (v > vmax) ? 7'd0 : v;
    endfunction

    function automatic logic [2:0] cont_of(input logic [2:0] st);
        case (st)
            ST_SET_H:  return 3'b100;
            ST_SET_M:  return 3'b010;
            ST_SET_S:  return 3'b001;
            ST_COMMIT: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  cont_q, cont_d;
    logic [6:0]  hora_q, hora_d, min_q, min_d, sec_q, sec_d;
    logic        blink_q, blink_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;
    logic        mode_prev_q, mode_prev_d;
    logic        up_prev_q, up_prev_d;
    logic        down_prev_q, down_prev_d;

    logic press_mode, press_up, press_down, any_press, step_up, step_down;

    // Next-state, field editing, timeout, blink and commit-hold logic.
    always_comb begin
        press_mode = btn_mode & ~mode_prev_q;
        press_up   = btn_up & ~up_prev_q;
        press_down = btn_down & ~down_prev_q;
        any_press  = press_mode | press_up | press_down;
        step_up    = press_up & ~press_down;
        step_down  = press_down & ~press_up;

        mode_prev_d  = btn_mode;
        up_prev_d    = btn_up;
        down_prev_d  = btn_down;
        state_d      = state_q;
        hora_d       = hora_q;
        min_d        = min_q;
        sec_d        = sec_q;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        commit_cnt_d = commit_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (press_mode) begin
                    hora_d  = field_clamp(run_hora, HORA_MAX);
                    min_d   = field_clamp(run_min, MS_MAX);
                    sec_d   = field_clamp(run_sec, MS_MAX);
                    state_d = ST_SET_H;
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (press_mode) begin
                    if (state_q == ST_SET_H)      state_d = ST_SET_M;
                    else if (state_q == ST_SET_M) state_d = ST_SET_S;
                    else                          state_d = ST_COMMIT;
                end else if (any_press) begin
                    // Any press (including a cancelling up+down pair) restarts
                    // the idle timeout and the blink phase.
                    idle_cnt_d  = 32'd0;
                    blink_cnt_d = 32'd0;
                    blink_d     = 1'b1;
                    if (state_q == ST_SET_H) begin
                        if (step_up)        hora_d = field_inc(hora_q, HORA_MAX);
                        else if (step_down) hora_d = field_dec(hora_q, HORA_MAX);
                    end else if (state_q == ST_SET_M) begin
                        if (step_up)        min_d = field_inc(min_q, MS_MAX);
                        else if (step_down) min_d = field_dec(min_q, MS_MAX);
                    end else begin
                        if (step_up)        sec_d = field_inc(sec_q, MS_MAX);
                        else if (step_down) sec_d = field_dec(sec_q, MS_MAX);
                    end
                end else if (idle_cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_d     = ~blink_q;
                        blink_cnt_d = 32'd0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 32'd1;
                    end
                end
            end
            ST_COMMIT: begin
                if (commit_cnt_q == COMMIT_LAST) state_d = ST_RUN;
                else                             commit_cnt_d = commit_cnt_q + 32'd1;
            end
            default: state_d = ST_RUN;
        endcase

        // Every state change restarts all counters; SET states open with blink on.
        if (state_d != state_q) begin
            idle_cnt_d   = 32'd0;
            blink_cnt_d  = 32'd0;
            commit_cnt_d = 32'd0;
            blink_d      = (state_d == ST_SET_H) || (state_d == ST_SET_M) || (state_d == ST_SET_S);
        end

        cont_d = cont_of(state_d);
    end

    // State and output registers; reset is asynchronous, active-low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cont_q       <= 3'b000;
            hora_q       <= 7'd0;
            min_q        <= 7'd0;
            sec_q        <= 7'd0;
            blink_q      <= 1'b0;
            blink_cnt_q  <= 32'd0;
            idle_cnt_q   <= 32'd0;
            commit_cnt_q <= 32'd0;
            mode_prev_q  <= 1'b0;
            up_prev_q    <= 1'b0;
            down_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            hora_q       <= hora_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            mode_prev_q  <= mode_prev_d;
            up_prev_q    <= up_prev_d;
            down_prev_q  <= down_prev_d;
        end
    end

    assign cont  = cont_q;
    assign hora  = hora_q;
    assign min   = min_q;
    assign sec   = sec_q;
    assign blink = blink_q;

endmodule
